axis_window_stats: RTL and testbench
====================================

// Module: axis_window_stats
// PURPOSE
//  Zero-latency AXI-Stream tap; in_* wired straight to out_*, TREADY straight back.
//  Counts flits, packets, bytes (TKEEP popcount), stall cycles and max packet length
//  over a fixed window of WINDOW_CYCLES clocks, then publishes a registered snapshot
//  with a one-cycle snap_valid strobe. Sits inline on middleware links for throughput/backpressure profiling.
// PARAMETERS
//  DATA_WIDTH    64    TDATA width in bits; multiple of 8; TKEEP is DATA_WIDTH/8 bits
//  CNT_WIDTH     32    width of every counter and snapshot output
//  WINDOW_CYCLES 1024  window length in clk cycles; >=2
//  SATURATE      1     1: counters hold at all-ones; 0: counters wrap modulo 2^CNT_WIDTH
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst          in   1           reset, synchronous, active-high
//  in_TDATA/TVALID/TKEEP/TDEST/TID/TLAST  in  per AXIS  monitored input stream
//  in_TREADY    out  1           = out_TREADY
//  out_TDATA/TVALID/TKEEP/TDEST/TID/TLAST out per AXIS  = corresponding in_* signals
//  out_TREADY   in   1           downstream ready
//  clear        in   1           sync restart of live counters and window timer
//  snap_valid   out  1           one-cycle pulse: snapshot registers just updated
//  snap_flits   out  CNT_WIDTH   handshakes (TVALID&&TREADY) in last window
//  snap_pkts    out  CNT_WIDTH   handshakes with TLAST in last window
//  snap_bytes   out  CNT_WIDTH   sum of popcount(TKEEP) over handshakes in last window
//  snap_stalls  out  CNT_WIDTH   cycles with TVALID && !TREADY in last window
//  snap_max_len out  CNT_WIDTH   longest packet (flits) completed in last window
// BEHAVIOUR
//  - Passthrough purely combinational; rst/clear never affect the data path.
//  - rst: window timer, all live counters, pkt_len_cur, all snap_* and snap_valid -> 0.
//  - Window timer win_cnt, $clog2(WINDOW_CYCLES) bits, counts 0..WINDOW_CYCLES-1, wraps.
//  - Every cycle: flit+=hs; pkt+=hs&&TLAST; bytes+=hs?popcount(TKEEP):0; stall+=TVALID&&!TREADY.
//  - pkt_len_cur: +1 per non-last handshake; on TLAST handshake len=pkt_len_cur+1,
//    live_max=max(live_max,len), pkt_len_cur->0. Never cleared at window end (spans windows).
//  - Window end (win_cnt==WINDOW_CYCLES-1, no clear): at that edge snap_* <= live value
//    INCLUDING the current cycle's event; live counters/live_max <= 0; snap_valid=1 next
//    cycle only. First snapshot after rst: snap_valid high in cycle WINDOW_CYCLES.
//  - clear: live counters, live_max, pkt_len_cur, win_cnt <= 0; snap_* unchanged; no
//    snap_valid; clear wins over a coincident window end (that snapshot is dropped).
//    Next snap_valid exactly WINDOW_CYCLES cycles after the clear cycle.
//  - Width: popcount DATA_WIDTH/8 zero-extended to CNT_WIDTH; pkt_len_cur is CNT_WIDTH.
//  - SATURATE=1: any add overflowing 2^CNT_WIDTH-1 yields 2^CNT_WIDTH-1 (incl. pkt_len_cur).
//    SATURATE=0: plain modulo wrap.
//  - rst mid-window: everything zero next cycle, window restarts at win_cnt=0.
// TESTING (DATA_WIDTH=32, WINDOW_CYCLES=16 unless stated)
//  1 rst held 3 cycles, random stream -> all snap_* 0, snap_valid 0; out_* == in_* each cycle.
//  2 16 cycles VALID=READY=1, TKEEP=4'hF, TLAST every 4th -> snap_valid once at cycle 16;
//    flits=16, pkts=4, bytes=64, stalls=0, max_len=4.
//  3 VALID=1,READY=0 x5; then 3 hs, last TKEEP=4'b0111 TLAST=1; idle -> stalls=5, flits=3,
//    bytes=11, pkts=1, max_len=3.
//  4 CNT_WIDTH=4, WINDOW_CYCLES=32, 20 hs -> SATURATE=1: snap_flits=15; SATURATE=0: 4.
//  5 clear at win_cnt=10 after 8 hs -> no pulse at cycle 16; pulse 16 cycles after clear;
//    snap_* keep prior values until then; clear at win_cnt=15 -> that snapshot dropped.
//  6 6-flit pkt, 3 flits in window N, 3 in N+1 -> window N pkts=0,max_len=0;
//    window N+1 pkts=1, max_len=6, flits=3.
//  7 rst at win_cnt=7 during traffic -> snap_* 0 next cycle; next pulse 16 cycles after rst release.

Source files
------------

// File: rtl/axis_window_stats.sv
// axis_window_stats: zero-latency AXI-Stream tap that profiles flits, packets, bytes,
// stalls and max packet length per fixed window and publishes a registered snapshot.
module axis_window_stats #(
    parameter int DATA_WIDTH    = 64,
    parameter int CNT_WIDTH     = 32,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SATURATE      = 1,
    parameter int DEST_WIDTH    = 4,
    parameter int ID_WIDTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_TDATA,
    input  logic                    in_TVALID,
    input  logic [DATA_WIDTH/8-1:0] in_TKEEP,
    input  logic [DEST_WIDTH-1:0]   in_TDEST,
    input  logic [ID_WIDTH-1:0]     in_TID,
    input  logic                    in_TLAST,
    output logic                    in_TREADY,
    output logic [DATA_WIDTH-1:0]   out_TDATA,
    output logic                    out_TVALID,
    output logic [DATA_WIDTH/8-1:0] out_TKEEP,
    output logic [DEST_WIDTH-1:0]   out_TDEST,
    output logic [ID_WIDTH-1:0]     out_TID,
    output logic                    out_TLAST,
    input  logic                    out_TREADY,
    input  logic                    clear,
    output logic                    snap_valid,
    output logic [CNT_WIDTH-1:0]    snap_flits,
    output logic [CNT_WIDTH-1:0]    snap_pkts,
    output logic [CNT_WIDTH-1:0]    snap_bytes,
    output logic [CNT_WIDTH-1:0]    snap_stalls,
    output logic [CNT_WIDTH-1:0]    snap_max_len
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int WW = $clog2(WINDOW_CYCLES);
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    // Overflow either pins at all-ones or wraps, depending on SATURATE.
    function automatic cnt_t add(input cnt_t a, input cnt_t b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (SATURATE != 0 && s[CNT_WIDTH]) ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    assign in_TREADY  = out_TREADY;
    assign out_TDATA  = in_TDATA;
    assign out_TVALID = in_TVALID;
    assign out_TKEEP  = in_TKEEP;
    assign out_TDEST  = in_TDEST;
    assign out_TID    = in_TID;
    assign out_TLAST  = in_TLAST;

    logic [WW-1:0] win_cnt_q, win_cnt_d;
    cnt_t flits_q, flits_d, pkts_q, pkts_d, bytes_q, bytes_d, stalls_q, stalls_d;
    cnt_t max_q, max_d, pkt_len_q, pkt_len_d;
    cnt_t snap_flits_q, snap_flits_d, snap_pkts_q, snap_pkts_d, snap_bytes_q, snap_bytes_d;
    cnt_t snap_stalls_q, snap_stalls_d, snap_max_q, snap_max_d;
    logic snap_valid_q, snap_valid_d;
    logic hs, pkt_end, restart, publish;
    cnt_t keep_cnt, len, flits_n, pkts_n, bytes_n, stalls_n, max_n;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KW; i++) keep_cnt = keep_cnt + cnt_t'(in_TKEEP[i]);
        hs       = in_TVALID && out_TREADY;
        pkt_end  = hs && in_TLAST;
        restart  = clear || win_cnt_q == WW'(WINDOW_CYCLES - 1);
        publish  = !clear && win_cnt_q == WW'(WINDOW_CYCLES - 1);
        len      = add(pkt_len_q, cnt_t'(1));
        flits_n  = add(flits_q, cnt_t'(hs));
        pkts_n   = add(pkts_q, cnt_t'(pkt_end));
        bytes_n  = add(bytes_q, hs ? keep_cnt : '0);
        stalls_n = add(stalls_q, cnt_t'(in_TVALID && !out_TREADY));
        max_n    = (pkt_end && len > max_q) ? len : max_q;
        // Packet length deliberately survives window boundaries; only clear resets it.
        pkt_len_d     = clear ? '0 : hs ? (in_TLAST ? '0 : len) : pkt_len_q;
        win_cnt_d     = restart ? '0 : win_cnt_q + WW'(1);
        flits_d       = restart ? '0 : flits_n;
        pkts_d        = restart ? '0 : pkts_n;
        bytes_d       = restart ? '0 : bytes_n;
        stalls_d      = restart ? '0 : stalls_n;
        max_d         = restart ? '0 : max_n;
        snap_flits_d  = publish ? flits_n : snap_flits_q;
        snap_pkts_d   = publish ? pkts_n : snap_pkts_q;
        snap_bytes_d  = publish ? bytes_n : snap_bytes_q;
        snap_stalls_d = publish ? stalls_n : snap_stalls_q;
        snap_max_d    = publish ? max_n : snap_max_q;
        snap_valid_d  = publish;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q     <= '0;
            flits_q       <= '0;
            pkts_q        <= '0;
            bytes_q       <= '0;
            stalls_q      <= '0;
            max_q         <= '0;
            pkt_len_q     <= '0;
            snap_flits_q  <= '0;
            snap_pkts_q   <= '0;
            snap_bytes_q  <= '0;
            snap_stalls_q <= '0;
            snap_max_q    <= '0;
            snap_valid_q  <= 1'b0;
        end else begin
            win_cnt_q     <= win_cnt_d;
            flits_q       <= flits_d;
            pkts_q        <= pkts_d;
            bytes_q       <= bytes_d;
            stalls_q      <= stalls_d;
            max_q         <= max_d;
            pkt_len_q     <= pkt_len_d;
            snap_flits_q  <= snap_flits_d;
            snap_pkts_q   <= snap_pkts_d;
            snap_bytes_q  <= snap_bytes_d;
            snap_stalls_q <= snap_stalls_d;
            snap_max_q    <= snap_max_d;
            snap_valid_q  <= snap_valid_d;
        end
    end

    assign snap_valid   = snap_valid_q;
    assign snap_flits   = snap_flits_q;
    assign snap_pkts    = snap_pkts_q;
    assign snap_bytes   = snap_bytes_q;
    assign snap_stalls  = snap_stalls_q;
    assign snap_max_len = snap_max_q;
endmodule

// File: tb/tb_axis_window_stats.sv
// tb_axis_window_stats: directed and random stream against a window-accounting model,
// plus two narrow-counter instances exercising saturate and wrap modes.
module tb_axis_window_stats;
    logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
    logic [31:0] in_TDATA = '0;
    logic in_TVALID = 1'b0, in_TLAST = 1'b0, out_TREADY = 1'b0;
    logic [3:0] in_TKEEP = '0, in_TDEST = '0, in_TID = '0;
    logic in_TREADY, out_TVALID, out_TLAST, snap_valid;
    logic [31:0] out_TDATA;
    logic [3:0] out_TKEEP, out_TDEST, out_TID;
    logic [31:0] snap_flits, snap_pkts, snap_bytes, snap_stalls, snap_max_len;
    logic s_rdy, s_v, s_l, s_sv, w_rdy, w_v, w_l, w_sv;
    logic [31:0] s_d, w_d;
    logic [3:0] s_k, s_de, s_id, w_k, w_de, w_id;
    logic [3:0] s_fl, s_pk, s_by, s_st, s_mx, w_fl, w_pk, w_by, w_st, w_mx;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    axis_window_stats #(.DATA_WIDTH(32), .CNT_WIDTH(32), .WINDOW_CYCLES(16), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TKEEP(in_TKEEP),
        .in_TDEST(in_TDEST), .in_TID(in_TID), .in_TLAST(in_TLAST), .in_TREADY(in_TREADY),
        .out_TDATA(out_TDATA), .out_TVALID(out_TVALID), .out_TKEEP(out_TKEEP), .out_TDEST(out_TDEST),
        .out_TID(out_TID), .out_TLAST(out_TLAST), .out_TREADY(out_TREADY), .clear(clear),
        .snap_valid(snap_valid), .snap_flits(snap_flits), .snap_pkts(snap_pkts), .snap_bytes(snap_bytes),
        .snap_stalls(snap_stalls), .snap_max_len(snap_max_len));

    axis_window_stats #(.DATA_WIDTH(32), .CNT_WIDTH(4), .WINDOW_CYCLES(32), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TKEEP(in_TKEEP),
        .in_TDEST(in_TDEST), .in_TID(in_TID), .in_TLAST(in_TLAST), .in_TREADY(s_rdy),
        .out_TDATA(s_d), .out_TVALID(s_v), .out_TKEEP(s_k), .out_TDEST(s_de),
        .out_TID(s_id), .out_TLAST(s_l), .out_TREADY(out_TREADY), .clear(clear),
        .snap_valid(s_sv), .snap_flits(s_fl), .snap_pkts(s_pk), .snap_bytes(s_by),
        .snap_stalls(s_st), .snap_max_len(s_mx));

    axis_window_stats #(.DATA_WIDTH(32), .CNT_WIDTH(4), .WINDOW_CYCLES(32), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TKEEP(in_TKEEP),
        .in_TDEST(in_TDEST), .in_TID(in_TID), .in_TLAST(in_TLAST), .in_TREADY(w_rdy),
        .out_TDATA(w_d), .out_TVALID(w_v), .out_TKEEP(w_k), .out_TDEST(w_de),
        .out_TID(w_id), .out_TLAST(w_l), .out_TREADY(out_TREADY), .clear(clear),
        .snap_valid(w_sv), .snap_flits(w_fl), .snap_pkts(w_pk), .snap_bytes(w_by),
        .snap_stalls(w_st), .snap_max_len(w_mx));

    // Reference: raw unbounded totals per window, clipped to counter width only when published.
    longint t_flits, t_pkts, t_bytes, t_stalls, t_max, cur_len;
    longint e_flits, e_pkts, e_bytes, e_stalls, e_max;
    int m_win;
    bit e_valid;

    function automatic longint fit(input longint x);
        longint mx = 64'hFFFF_FFFF;
        return x > mx ? mx : x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit r, input logic [3:0] k, input bit l, input bit c, input bit rs);
        longint len;
        in_TVALID = v; out_TREADY = r; in_TKEEP = k; in_TLAST = l; clear = c; rst = rs;
        in_TDATA = $urandom; in_TDEST = 4'($urandom); in_TID = 4'($urandom);
        #1;
        chk("passthrough", {out_TDATA, out_TVALID, out_TKEEP, out_TDEST, out_TID, out_TLAST, in_TREADY},
            {in_TDATA, in_TVALID, in_TKEEP, in_TDEST, in_TID, in_TLAST, out_TREADY});
        @(posedge clk);
        if (rs || c) begin
            {t_flits, t_pkts, t_bytes, t_stalls, t_max, cur_len} = '0;
            m_win = 0; e_valid = 0;
            if (rs) {e_flits, e_pkts, e_bytes, e_stalls, e_max} = '0;
        end else begin
            if (v && r) begin
                t_flits++;
                t_bytes += $countones(k);
                if (l) begin
                    len = fit(cur_len + 1);
                    t_pkts++;
                    if (len > t_max) t_max = len;
                    cur_len = 0;
                end else cur_len++;
            end
            if (v && !r) t_stalls++;
            e_valid = (m_win == 15);
            if (m_win == 15) begin
                e_flits = fit(t_flits); e_pkts = fit(t_pkts); e_bytes = fit(t_bytes);
                e_stalls = fit(t_stalls); e_max = t_max;
                {t_flits, t_pkts, t_bytes, t_stalls, t_max} = '0;
                m_win = 0;
            end else m_win++;
        end
        #1;
        chk("snap_valid", snap_valid, e_valid);
        chk("snap_flits", snap_flits, e_flits);
        chk("snap_pkts", snap_pkts, e_pkts);
        chk("snap_bytes", snap_bytes, e_bytes);
        chk("snap_stalls", snap_stalls, e_stalls);
        chk("snap_max_len", snap_max_len, e_max);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 1'($urandom), 4'($urandom), 1'($urandom), 0, 0);
    endtask

    initial begin
        @(negedge clk);
        repeat (3) step(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 0, 1);
        chk("rst_valid", snap_valid, 0);
        chk("rst_flits", snap_flits, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 4'hF, i % 4 == 3, 0, 0);
            if (i == 14) chk("t2_no_early_pulse", snap_valid, 0);
        end
        chk("t2_valid", snap_valid, 1);
        chk("t2_flits", snap_flits, 16);
        chk("t2_pkts", snap_pkts, 4);
        chk("t2_bytes", snap_bytes, 64);
        chk("t2_stalls", snap_stalls, 0);
        chk("t2_max", snap_max_len, 4);
        repeat (5) step(1, 0, 4'hF, 0, 0, 0);
        step(1, 1, 4'hF, 0, 0, 0);
        step(1, 1, 4'hF, 0, 0, 0);
        step(1, 1, 4'b0111, 1, 0, 0);
        idle(8);
        chk("t3_stalls", snap_stalls, 5);
        chk("t3_flits", snap_flits, 3);
        chk("t3_bytes", snap_bytes, 11);
        chk("t3_pkts", snap_pkts, 1);
        chk("t3_max", snap_max_len, 3);
        repeat (8) step(1, 1, 4'hF, 0, 0, 0);
        idle(2);
        step(0, 1, 4'hF, 0, 1, 0);
        idle(15);
        chk("t5_held_valid", snap_valid, 0);
        chk("t5_held_flits", snap_flits, 3);
        idle(1);
        chk("t5_pulse", snap_valid, 1);
        chk("t5_flits", snap_flits, 0);
        repeat (15) step(1, 1, 4'hF, 0, 0, 0);
        step(1, 1, 4'hF, 0, 1, 0);
        chk("t5_drop_valid", snap_valid, 0);
        chk("t5_drop_flits", snap_flits, 0);
        idle(13);
        repeat (3) step(1, 1, 4'hF, 0, 0, 0);
        chk("t6a_pkts", snap_pkts, 0);
        chk("t6a_max", snap_max_len, 0);
        chk("t6a_flits", snap_flits, 3);
        step(1, 1, 4'hF, 0, 0, 0);
        step(1, 1, 4'hF, 0, 0, 0);
        step(1, 1, 4'hF, 1, 0, 0);
        idle(13);
        chk("t6b_pkts", snap_pkts, 1);
        chk("t6b_max", snap_max_len, 6);
        chk("t6b_flits", snap_flits, 3);
        repeat (7) step(1, 1'($urandom), 4'($urandom), 1'($urandom), 0, 0);
        step(1, 1, 4'hF, 0, 0, 1);
        chk("t7_flits", snap_flits, 0);
        repeat (15) step(1, 1'($urandom), 4'($urandom), 1'($urandom), 0, 0);
        chk("t7_no_pulse", snap_valid, 0);
        step(1, 1, 4'hF, 0, 0, 0);
        chk("t7_pulse", snap_valid, 1);
        repeat (400) step(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 39) == 0, 0);
        step(0, 1, 4'hF, 0, 0, 1);
        repeat (20) step(1, 1, 4'hF, 0, 0, 0);
        idle(11);
        chk("t4_no_pulse", s_sv, 0);
        idle(1);
        chk("t4_sat_valid", s_sv, 1);
        chk("t4_sat_flits", s_fl, 15);
        chk("t4_sat_bytes", s_by, 15);
        chk("t4_wrap_valid", w_sv, 1);
        chk("t4_wrap_flits", w_fl, 4);
        chk("t4_wrap_bytes", w_by, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
